// File: rtl/uart_pkg.sv
// Shared UART definitions: RX sampler state encoding and the default
// link parameters used by the TX, RX FSM and RX sampler blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'b00,
        START = 2'b01,
        BITS  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    // 50 MHz / (115200 * 16), 8 data bits with one parity bit.
    localparam int DEF_CLK_DIV   = 27;
    localparam int DEF_OVS       = 16;
    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_PARITY_EN = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Sampler-to-RX-FSM bundle: start pulse, decided bits and stop-bit status.
interface uart_rx_sampler_if;
    logic start_bit;
    logic rx_bit;
    logic bit_valid;
    logic stop_ok;
    logic frame_err;
    logic break_det;
    logic busy;

    modport master (output start_bit, rx_bit, bit_valid, stop_ok, frame_err, break_det, busy);
    modport slave  (input  start_bit, rx_bit, bit_valid, stop_ok, frame_err, break_det, busy);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; reset value is a parameter
// so an idle-high line does not look like activity coming out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front-end: synchronize RXD, oversample, validate the start bit
// by mid-bit majority vote and strobe one decided bit per bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int OVS       = DEF_OVS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PARITY_EN = DEF_PARITY_EN
) (
    input  logic CLK,
    input  logic RST,
    input  logic RXD,
    input  logic EN,
    uart_rx_sampler_if.master rx
);
    localparam int NBITS = DATA_BITS + PARITY_EN;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW    = $clog2(OVS);
    localparam int BW    = $clog2(NBITS + 1);

    rx_state_t         state;
    logic [PW-1:0]     presc;
    logic [OW-1:0]     ovs_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              rxd_s, rxd_prev, fall;
    logic              s0, s1, all_zero;
    logic              start_bit_r, rx_bit_r, bit_valid_r, stop_ok_r, frame_err_r, break_det_r, busy_r;
    logic              tick, wrap, samp_a, samp_b, decide, maj;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.CLK(CLK), .RST(RST), .d(RXD), .q(rxd_s));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_prev <= 1'b1;
            fall     <= 1'b0;
        end else begin
            rxd_prev <= rxd_s;
            fall     <= rxd_prev & ~rxd_s;
        end
    end

    // A sample point is named by the ovs_cnt value its tick advances into,
    // so the decision lands on the tick entering OVS/2+1.
    assign tick   = (state != HUNT) && (presc == PW'(CLK_DIV - 1));
    assign wrap   = tick && (ovs_cnt == OW'(OVS - 1));
    assign samp_a = tick && (ovs_cnt == OW'(OVS / 2 - 2));
    assign samp_b = tick && (ovs_cnt == OW'(OVS / 2 - 1));
    assign decide = tick && (ovs_cnt == OW'(OVS / 2));
    assign maj    = maj3(s0, s1, rxd_s);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= HUNT;
            presc       <= '0;
            ovs_cnt     <= '0;
            bit_cnt     <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            all_zero    <= 1'b0;
            start_bit_r <= 1'b1;
            rx_bit_r    <= 1'b1;
            bit_valid_r <= 1'b0;
            stop_ok_r   <= 1'b0;
            frame_err_r <= 1'b0;
            break_det_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            start_bit_r <= 1'b1;
            bit_valid_r <= 1'b0;
            stop_ok_r   <= 1'b0;
            frame_err_r <= 1'b0;
            break_det_r <= 1'b0;
            if (!EN) begin
                state    <= HUNT;
                presc    <= '0;
                ovs_cnt  <= '0;
                bit_cnt  <= '0;
                rx_bit_r <= 1'b1;
                busy_r   <= 1'b0;
            end else begin
                if (state == HUNT) begin
                    presc   <= '0;
                    ovs_cnt <= '0;
                end else begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) ovs_cnt <= wrap ? '0 : ovs_cnt + 1'b1;
                end
                if (samp_a) s0 <= rxd_s;
                if (samp_b) s1 <= rxd_s;

                unique case (state)
                    HUNT: if (fall) begin
                        state    <= START;
                        bit_cnt  <= '0;
                        all_zero <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                    START: if (decide) begin
                        if (maj) begin
                            state  <= HUNT;
                            busy_r <= 1'b0;
                        end else begin
                            start_bit_r <= 1'b0;
                        end
                    end else if (wrap) begin
                        state <= BITS;
                    end
                    BITS: if (decide) begin
                        rx_bit_r    <= maj;
                        bit_valid_r <= 1'b1;
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (maj) all_zero <= 1'b0;
                    end else if (wrap && bit_cnt == BW'(NBITS)) begin
                        state <= STOP;
                    end
                    // Leave half a bit early so a back-to-back start edge is caught.
                    STOP: if (decide) begin
                        state  <= HUNT;
                        busy_r <= 1'b0;
                        if (maj) begin
                            stop_ok_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                            break_det_r <= all_zero;
                        end
                    end
                endcase
            end
        end
    end

    assign rx.start_bit = start_bit_r;
    assign rx.rx_bit    = rx_bit_r;
    assign rx.bit_valid = bit_valid_r;
    assign rx.stop_ok   = stop_ok_r;
    assign rx.frame_err = frame_err_r;
    assign rx.break_det = break_det_r;
    assign rx.busy      = busy_r;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: table of frames plus hand sequences for
// glitch, break, fast back-to-back frames, and mid-frame RST / EN abort.
module tb_uart_rx_sampler;
    localparam int BP = 64;  // CLK per bit with CLK_DIV=4, OVS=16

    logic CLK, RST, RXD, EN;
    uart_rx_sampler_if rx_if ();

    uart_rx_sampler #(.CLK_DIV(4), .OVS(16), .DATA_BITS(8), .PARITY_EN(1)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .EN(EN), .rx(rx_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    // Event log gathered away from the active edge.
    logic bits_q[$];
    int   times_q[$];
    int   n_start, n_stop, n_ferr, n_brk, n_pair, n_overlap, t_start;

    always @(negedge CLK) begin
        int k;
        if (!RST) begin
            k = int'(!rx_if.start_bit) + int'(rx_if.bit_valid) + int'(rx_if.stop_ok) + int'(rx_if.frame_err);
            if (k > 1) n_overlap++;
            if (!rx_if.start_bit) begin n_start++; t_start = cyc; end
            if (rx_if.bit_valid) begin bits_q.push_back(rx_if.rx_bit); times_q.push_back(cyc); end
            if (rx_if.stop_ok) n_stop++;
            if (rx_if.frame_err) n_ferr++;
            if (rx_if.break_det) n_brk++;
            if (rx_if.break_det && rx_if.frame_err) n_pair++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic clear_log();
        bits_q.delete();
        times_q.delete();
        n_start = 0; n_stop = 0; n_ferr = 0; n_brk = 0; n_pair = 0; t_start = -1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        RXD = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bp);
        drive_bit(1'b0, bp);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bp);
        drive_bit(par, bp);
        drive_bit(stp, bp);
    endtask

    // Bits received from log offset 'base' packed LSB-first into a 9-bit word.
    function automatic int word_at(input int base);
        int w = 0;
        for (int i = 0; i < 9; i++)
            if (base + i < bits_q.size() && bits_q[base + i] === 1'b1) w |= (1 << i);
        return w;
    endfunction

    function automatic int bad_spacing();
        int b = 0;
        if (times_q.size() > 0 && times_q[0] - t_start != BP) b++;
        for (int i = 1; i < times_q.size(); i++)
            if (times_q[i] - times_q[i-1] != BP) b++;
        return b;
    endfunction

    function automatic int outs();
        return int'({rx_if.start_bit, rx_if.rx_bit, rx_if.bit_valid, rx_if.stop_ok,
                     rx_if.frame_err, rx_if.break_det, rx_if.busy});
    endfunction

    typedef struct {
        string      name;
        logic [7:0] d;
        logic       par;
        logic       stp;
        int         e_stop;
        int         e_ferr;
    } vec_t;

    vec_t vecs[7];
    int c0;

    task automatic good_frame(input string name, input logic [7:0] d, input logic par);
        clear_log();
        send_frame(d, par, 1'b1, BP);
        drive_bit(1'b1, 2 * BP);
        chk({name, " start"}, n_start, 1);
        chk({name, " nbits"}, bits_q.size(), 9);
        chk({name, " word"}, word_at(0), int'({par, d}));
        chk({name, " stop_ok"}, n_stop, 1);
        chk({name, " frame_err"}, n_ferr, 0);
    endtask

    initial begin
        vecs[0] = '{"a5",     8'hA5, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{"3c",     8'h3C, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{"stop0",  8'h81, 1'b0, 1'b0, 0, 1};
        vecs[3] = '{"3c_aft", 8'h3C, 1'b0, 1'b1, 1, 0};
        vecs[4] = '{"zero",   8'h00, 1'b0, 1'b1, 1, 0};
        vecs[5] = '{"ff",     8'hFF, 1'b0, 1'b1, 1, 0};
        vecs[6] = '{"5a_p1",  8'h5A, 1'b1, 1'b1, 1, 0};

        RST = 1'b1; EN = 1'b1; RXD = 1'b1; n_overlap = 0;
        clear_log();
        repeat (3) @(negedge CLK);
        chk("reset outs", outs(), 7'b1100000);
        RST = 1'b0;
        drive_bit(1'b1, 20);

        foreach (vecs[v]) begin
            clear_log();
            c0 = cyc;
            send_frame(vecs[v].d, vecs[v].par, vecs[v].stp, BP);
            drive_bit(1'b1, 2 * BP);
            chk({vecs[v].name, " start"}, n_start, 1);
            chk({vecs[v].name, " start_lat"}, t_start - c0, 40);
            chk({vecs[v].name, " nbits"}, bits_q.size(), 9);
            chk({vecs[v].name, " word"}, word_at(0), int'({vecs[v].par, vecs[v].d}));
            chk({vecs[v].name, " spacing"}, bad_spacing(), 0);
            chk({vecs[v].name, " stop_ok"}, n_stop, vecs[v].e_stop);
            chk({vecs[v].name, " frame_err"}, n_ferr, vecs[v].e_ferr);
            chk({vecs[v].name, " break"}, n_brk, 0);
            chk({vecs[v].name, " busy"}, int'(rx_if.busy), 0);
        end

        // Short low glitch must be rejected by the start-bit vote.
        clear_log();
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 3 * BP);
        chk("glitch start", n_start, 0);
        chk("glitch busy", int'(rx_if.busy), 0);
        chk("glitch bits", bits_q.size(), 0);
        good_frame("post_glitch", 8'hA5, 1'b0);

        // Break: line low for 12 bit times, then low held with no new start.
        clear_log();
        drive_bit(1'b0, 12 * BP);
        chk("break start", n_start, 1);
        chk("break word", word_at(0), 0);
        chk("break frame_err", n_ferr, 1);
        chk("break det", n_brk, 1);
        chk("break pair", n_pair, 1);
        chk("break stop_ok", n_stop, 0);
        drive_bit(1'b0, 2 * BP);
        chk("break no restart", n_start, 1);
        drive_bit(1'b1, 2 * BP);
        good_frame("post_break", 8'h3C, 1'b0);

        // Back-to-back frames, second one ~3% fast.
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1, BP);
        send_frame(8'h3C, 1'b0, 1'b1, 62);
        drive_bit(1'b1, 2 * BP);
        chk("b2b start", n_start, 2);
        chk("b2b nbits", bits_q.size(), 18);
        chk("b2b word0", word_at(0), 9'h0A5);
        chk("b2b word1", word_at(9), 9'h03C);
        chk("b2b stop_ok", n_stop, 2);
        chk("b2b frame_err", n_ferr, 0);

        // RST during data bit 4.
        clear_log();
        drive_bit(1'b0, BP);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, BP);
        drive_bit(1'b0, BP / 2);
        chk("rst pre busy", int'(rx_if.busy), 1);
        chk("rst pre rx_bit", int'(rx_if.rx_bit), 0);
        RST = 1'b1;
        #1;
        chk("rst outs", outs(), 7'b1100000);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        drive_bit(1'b1, 3 * BP);
        good_frame("post_rst", 8'h3C, 1'b0);

        // EN deasserted during data bit 4.
        clear_log();
        drive_bit(1'b0, BP);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, BP);
        drive_bit(1'b0, BP / 2);
        chk("en pre busy", int'(rx_if.busy), 1);
        EN = 1'b0;
        @(negedge CLK);
        chk("en outs", outs(), 7'b1100000);
        drive_bit(1'b0, BP);
        chk("en no strobes", bits_q.size(), 4);
        RXD = 1'b1;
        drive_bit(1'b1, 10);
        EN = 1'b1;
        drive_bit(1'b1, 2 * BP);
        good_frame("post_en", 8'hA5, 1'b0);

        chk("strobe overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Receive front-end for the UART: synchronizes the asynchronous serial input, oversamples it, validates start bits with a mid-bit majority vote and delivers one decided bit per bit period to the RX control FSM and shift datapath. It sits directly upstream of the RX FSM. It drives the active-low `start_bit` that takes the FSM out of IDLE and the per-bit strobe that paces the shift register. It also checks the stop bit and flags line breaks.

## Interface
- `CLK_DIV`, 27 — CLK cycles per oversample tick (≥2); 50 MHz / (115200 × 16).
- `OVS`, 16 — oversample ticks per bit; even, ≥8.
- `DATA_BITS`, 8 — data bits per frame (5..8).
- `PARITY_EN`, 1 — 1: one parity bit follows the data bits.

- `CLK` in 1 — system clock.
- `RST` in 1 — reset, asynchronous, active-high.
- `RXD` in 1 — asynchronous serial line, idle high.
- `EN` in 1 — 0 forces HUNT and holds all strobes low.
- `start_bit` out 1 — active-low, one-CLK pulse on a validated start bit; 1 otherwise.
- `rx_bit` out 1 — decided value of the current data/parity bit; held until the next strobe.
- `bit_valid` out 1 — one-CLK strobe, `rx_bit` is new.
- `stop_ok` out 1 — one-CLK strobe, stop bit sampled 1.
- `frame_err` out 1 — one-CLK strobe, stop bit sampled 0.
- `break_det` out 1 — one-CLK strobe, whole frame including stop was 0; asserted together with `frame_err`.
- `busy` out 1 — high in START/BITS/STOP.

## Operation
- Reset values: `start_bit`=1, `rx_bit`=1, all strobes 0, `busy`=0, state HUNT, synchronizer flops 1, counters 0.
- Synchronizer: 2 flops on `RXD`. A third flop holds the previous value for falling-edge detection.
- Prescaler: counts 0..CLK_DIV-1 and emits `tick` at CLK_DIV-1. It is cleared on HUNT→START so that bit timing is phase-locked to the detected edge.
- `ovs_cnt`: 0..OVS-1, advances on `tick` and wraps to 0. The wrap marks a bit boundary.
- Majority: the 3 samples taken at `ovs_cnt` = OVS/2-1, OVS/2, OVS/2+1 decide the bit (≥2 ones → 1).
- States:
  - **HUNT:** on a synced falling edge, go to START and clear `ovs_cnt` and `bit_cnt`.
  - **START:** at the decision tick (OVS/2+1):
    - majority 1 → glitch; return to HUNT with no output.
    - majority 0 → pulse `start_bit` low and go to BITS on the next wrap.
  - **BITS:** at each decision tick, update `rx_bit`, pulse `bit_valid` and increment `bit_cnt`. After bit DATA_BITS+PARITY_EN-1 is decided, go to STOP on the next wrap.
  - **STOP:** at the decision tick:
    - majority 1 → `stop_ok`.
    - majority 0 → `frame_err`, plus `break_det` if every start, data, parity and stop bit was 0.

    Return to HUNT immediately, i.e. half a bit early, so back-to-back frames resync.
- The line is not sampled outside the decision window. Falling edges in START/BITS/STOP are ignored.
- `EN` deasserted mid-frame aborts to HUNT in the next CLK with no strobes. `RST` mid-frame restores all reset values asynchronously.
- A frame whose stop bit is 0 returns to HUNT. A low line does not generate a new falling edge, so after a break no start is detected until `RXD` returns high and falls again.

## Timing
- Edge on `RXD` to edge flag: 3 CLK (2 sync + edge register).
- Start-edge flag to `start_bit` low: (OVS/2+1)·CLK_DIV + 1 CLK. All outputs are registered and asserted the CLK after the decision tick.
- Consecutive `bit_valid` strobes are exactly OVS·CLK_DIV CLK apart. The first follows the `start_bit` pulse by OVS·CLK_DIV CLK.
- Strobes are never simultaneous, except `frame_err`+`break_det`.
- Baud tolerance is ±(OVS/2-2)/OVS of a bit accumulated over the frame.

## Structure
- A shared `uart_pkg` holds:
  - the state encoding (HUNT=2'b00, START=2'b01, BITS=2'b10, STOP=2'b11);
  - the defaults for CLK_DIV, OVS, DATA_BITS and PARITY_EN, shared with the TX and RX FSM blocks.
- One sub-module, `uart_sync2`: 2-flop synchronizer with parameterized reset value, reused by the TX CTS path.

## Test plan
- CLK_DIV=4, OVS=16, 8N+parity: send 0xA5, LSB first, even parity bit 0, stop 1 → `start_bit` low once; 9 `bit_valid` strobes 64 CLK apart with `rx_bit` = 1,0,1,0,0,1,0,1,0; `stop_ok`.
- 20-CLK low glitch on idle `RXD` → no `start_bit` pulse; back in HUNT; a following valid frame is received correctly.
- Frame with stop bit 0 → `frame_err`, no `stop_ok`; the next valid frame 0x3C is received.
- `RXD` held low for 12 bit times → `frame_err`+`break_det` in the same CLK; no new start until `RXD` rises and falls.
- Two back-to-back frames, the second sent at +3% baud → both bytes correct, `stop_ok` ×2.
- Assert `RST` and, separately, deassert `EN` during data bit 4 → outputs return to reset values, `busy`=0; the next frame decodes correctly.
